// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID pipeline register, 32x32 register file with
// write-through bypass, main/ALU control decoder and immediate extender.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [31:0] ImmExtD,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic        RegWriteD,
    output logic [1:0]  ResultSrcD,
    output logic        MemWriteD,
    output logic        JumpD,
    output logic        BranchD,
    output logic [2:0]  ALUControlD,
    output logic        ALUSrcD,
    output logic        IllegalD
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_src_t;

    logic [31:0] instr_r;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;
    logic        valid_r;
    logic [31:0] regs_r [32];

    logic [6:0]  op_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic        reg_write_s;
    logic [1:0]  result_src_s;
    logic        mem_write_s;
    logic        jump_s;
    logic        branch_s;
    logic        alu_src_s;
    logic [2:0]  alu_ctl_s;
    logic        illegal_s;
    logic        ctl_ok_s;
    logic [2:0]  funct_ctl_s;
    logic        f3_bad_s;
    logic        f7_bad_s;
    imm_src_t    imm_src_s;
    logic [31:0] imm_s;

    // IF/ID register; a bubble clears valid so the NOP never claims a write
    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            instr_r    <= NOP_INSTR;
            pc_r       <= 32'd0;
            pc_plus4_r <= 32'd0;
            valid_r    <= 1'b0;
        end else if (!StallD) begin
            instr_r    <= InstrF;
            pc_r       <= PCF;
            pc_plus4_r <= PCPlus4F;
            valid_r    <= 1'b1;
        end
    end

    // Register file write port; x0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            regs_r[RdW] <= ResultW;
        end
    end

    assign op_s = instr_r[6:0];
    assign f3_s = instr_r[14:12];
    assign f7_s = instr_r[31:25];
    assign Rs1D = instr_r[19:15];
    assign Rs2D = instr_r[24:20];
    assign RdD  = instr_r[11:7];
    assign PCD      = pc_r;
    assign PCPlus4D = pc_plus4_r;

    assign RD1D = (RegWriteW && (RdW != 5'd0) && (RdW == Rs1D)) ? ResultW : regs_r[Rs1D];
    assign RD2D = (RegWriteW && (RdW != 5'd0) && (RdW == Rs2D)) ? ResultW : regs_r[Rs2D];

    assign f7_bad_s = (op_s == OP_R) && (f7_s != 7'b0000000) && (f7_s != 7'b0100000);

    // ALU operation for R-type and I-ALU instructions from funct3/funct7
    always_comb begin
        funct_ctl_s = ALU_ADD;
        f3_bad_s    = 1'b0;
        case (f3_s)
            3'b000:  funct_ctl_s = ((op_s == OP_R) && f7_s[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctl_s = ALU_SLT;
            3'b110:  funct_ctl_s = ALU_OR;
            3'b111:  funct_ctl_s = ALU_AND;
            default: f3_bad_s    = 1'b1;
        endcase
    end

    // Main decoder
    always_comb begin
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        mem_write_s  = 1'b0;
        jump_s       = 1'b0;
        branch_s     = 1'b0;
        alu_src_s    = 1'b0;
        alu_ctl_s    = ALU_ADD;
        imm_src_s    = IMM_NONE;
        illegal_s    = 1'b0;
        case (op_s)
            OP_LOAD: begin
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                result_src_s = 2'b01;
                imm_src_s    = IMM_I;
            end
            OP_STORE: begin
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                imm_src_s   = IMM_S;
            end
            OP_R: begin
                reg_write_s = 1'b1;
                alu_ctl_s   = funct_ctl_s;
                illegal_s   = f3_bad_s | f7_bad_s;
            end
            OP_IALU: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                alu_ctl_s   = funct_ctl_s;
                imm_src_s   = IMM_I;
                illegal_s   = f3_bad_s;
            end
            OP_BEQ: begin
                branch_s  = 1'b1;
                alu_ctl_s = ALU_SUB;
                imm_src_s = IMM_B;
            end
            OP_JAL: begin
                reg_write_s  = 1'b1;
                jump_s       = 1'b1;
                alu_src_s    = 1'b1;
                result_src_s = 2'b10;
                imm_src_s    = IMM_J;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Immediate extender, sign always taken from bit 31
    always_comb begin
        imm_s = 32'd0;
        case (imm_src_s)
            IMM_I:   imm_s = {{20{instr_r[31]}}, instr_r[31:20]};
            IMM_S:   imm_s = {{20{instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
            IMM_B:   imm_s = {{19{instr_r[31]}}, instr_r[31], instr_r[7], instr_r[30:25],
                              instr_r[11:8], 1'b0};
            IMM_J:   imm_s = {{11{instr_r[31]}}, instr_r[31], instr_r[19:12], instr_r[20],
                              instr_r[30:21], 1'b0};
            default: imm_s = 32'd0;
        endcase
    end

    // Side-effecting controls only for a valid, legal instruction
    assign ctl_ok_s    = valid_r & ~illegal_s;
    assign RegWriteD   = reg_write_s & ctl_ok_s;
    assign MemWriteD   = mem_write_s & ctl_ok_s;
    assign JumpD       = jump_s & ctl_ok_s;
    assign BranchD     = branch_s & ctl_ok_s;
    assign ResultSrcD  = result_src_s;
    assign ALUSrcD     = alu_src_s;
    assign ALUControlD = alu_ctl_s;
    assign ImmExtD     = imm_s;
    assign IllegalD    = illegal_s;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// hazard/reset sequences and randomized traffic against a reference model.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ImmExtD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        MemWriteD;
    logic        JumpD;
    logic        BranchD;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD;
    logic        IllegalD;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .RD1D(RD1D), .RD2D(RD2D),
        .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .IllegalD(IllegalD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Expected decode of one instruction word
    typedef struct {
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw;
        logic        jmp;
        logic        br;
        logic [2:0]  actl;
        logic        asrc;
        logic        adc;
        logic        ill;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw;
        logic        jmp;
        logic        br;
        logic [2:0]  actl;
        logic        asrc;
        logic        adc;
        logic        ill;
        logic [31:0] imm;
    } vec_t;

    // Reference model state
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_regs [32];

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        d = '{rw: 1'b0, rsrc: 2'd0, mw: 1'b0, jmp: 1'b0, br: 1'b0, actl: 3'd0,
              asrc: 1'b0, adc: 1'b0, ill: 1'b0, imm: 32'd0};
        case (op)
            7'b0000011: begin d.rw = 1'b1; d.asrc = 1'b1; d.rsrc = 2'd1;
                              d.imm = 32'($signed(ins[31:20])); end
            7'b0100011: begin d.mw = 1'b1; d.asrc = 1'b1;
                              d.imm = 32'($signed({ins[31:25], ins[11:7]})); end
            7'b0110011: d.rw = 1'b1;
            7'b0010011: begin d.rw = 1'b1; d.asrc = 1'b1;
                              d.imm = 32'($signed(ins[31:20])); end
            7'b1100011: begin d.br = 1'b1; d.actl = 3'b001;
                              d.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
            7'b1101111: begin d.rw = 1'b1; d.jmp = 1'b1; d.rsrc = 2'd2; d.adc = 1'b1;
                              d.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
            default: d.ill = 1'b1;
        endcase
        if (op == 7'b0110011 || op == 7'b0010011) begin
            case (f3)
                3'b000:  d.actl = (op == 7'b0110011 && f7[5]) ? 3'b001 : 3'b000;
                3'b010:  d.actl = 3'b101;
                3'b110:  d.actl = 3'b011;
                3'b111:  d.actl = 3'b010;
                default: d.ill = 1'b1;
            endcase
            if (op == 7'b0110011 && f7 != 7'd0 && f7 != 7'd32) d.ill = 1'b1;
        end
        if (d.ill) begin
            d.rw = 1'b0; d.mw = 1'b0; d.br = 1'b0; d.jmp = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (RegWriteW && RdW != 5'd0 && RdW == a) return ResultW;
        return m_regs[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One rising edge; the model consumes the same inputs the DUT saw
    task automatic clk_edge();
        @(posedge clk);
        if (rst) begin
            m_instr = 32'h00000013; m_pc = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (FlushD) begin
                m_instr = 32'h00000013; m_pc = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            end else if (!StallD) begin
                m_instr = InstrF; m_pc = PCF; m_pc4 = PCPlus4F; m_valid = 1'b1;
            end
            if (RegWriteW && RdW != 5'd0) m_regs[RdW] = ResultW;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        dec_t e;
        #2;
        e = ref_decode(m_instr);
        if (!m_valid) begin
            e.rw = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jmp = 1'b0;
        end
        chk({tag, ".PCD"}, PCD, m_pc);
        chk({tag, ".PCPlus4D"}, PCPlus4D, m_pc4);
        chk({tag, ".Rs1D"}, 32'(Rs1D), 32'(m_instr[19:15]));
        chk({tag, ".Rs2D"}, 32'(Rs2D), 32'(m_instr[24:20]));
        chk({tag, ".RdD"}, 32'(RdD), 32'(m_instr[11:7]));
        chk({tag, ".RD1D"}, RD1D, exp_rd(m_instr[19:15]));
        chk({tag, ".RD2D"}, RD2D, exp_rd(m_instr[24:20]));
        chk({tag, ".ImmExtD"}, ImmExtD, e.imm);
        chk({tag, ".RegWriteD"}, 32'(RegWriteD), 32'(e.rw));
        chk({tag, ".MemWriteD"}, 32'(MemWriteD), 32'(e.mw));
        chk({tag, ".JumpD"}, 32'(JumpD), 32'(e.jmp));
        chk({tag, ".BranchD"}, 32'(BranchD), 32'(e.br));
        chk({tag, ".IllegalD"}, 32'(IllegalD), 32'(e.ill));
        if (!e.ill) begin
            chk({tag, ".ResultSrcD"}, 32'(ResultSrcD), 32'(e.rsrc));
            chk({tag, ".ALUControlD"}, 32'(ALUControlD), 32'(e.actl));
            if (!e.adc) chk({tag, ".ALUSrcD"}, 32'(ALUSrcD), 32'(e.asrc));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 7))
            0: ins[6:0] = 7'b0000011;
            1: ins[6:0] = 7'b0100011;
            2: ins[6:0] = 7'b0110011;
            3: ins[6:0] = 7'b0010011;
            4: ins[6:0] = 7'b1100011;
            5: ins[6:0] = 7'b1101111;
            6: ins[6:0] = 7'b0110011;
            default: ins[6:0] = 7'($urandom);
        endcase
        case ($urandom_range(0, 2))
            0: ins[31:25] = 7'b0000000;
            1: ins[31:25] = 7'b0100000;
            default: ins[31:25] = ins[31:25];
        endcase
        return ins;
    endfunction

    vec_t tab [12];

    initial begin
        tab[0]  = '{32'h00500093, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h00000005};
        tab[1]  = '{32'hFE000CE3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8};
        tab[2]  = '{32'h001000EF, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h00000800};
        tab[3]  = '{32'h0000007F, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 32'h00000000};
        tab[4]  = '{32'h023100B3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 32'h00000000};
        tab[5]  = '{32'h00512623, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000000C};
        tab[6]  = '{32'hFFC12303, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC};
        tab[7]  = '{32'h40218233, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h00000000};
        tab[8]  = '{32'hFFF0A093, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF};
        tab[9]  = '{32'h7F006113, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 32'h000007F0};
        tab[10] = '{32'h007372B3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'h00000000};
        tab[11] = '{32'h00109093, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h00000001};

        rst = 1'b1; StallD = 1'b0; FlushD = 1'b0;
        InstrF = 32'd0; PCF = 32'd0; PCPlus4F = 32'd0;
        RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
        m_instr = 32'h00000013; m_pc = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        #1;
        clk_edge();
        clk_edge();

        // Reset state
        #2;
        chk("rst.RegWriteD", 32'(RegWriteD), 32'd0);
        chk("rst.ALUSrcD", 32'(ALUSrcD), 32'd1);
        chk("rst.ALUControlD", 32'(ALUControlD), 32'd0);
        chk("rst.IllegalD", 32'(IllegalD), 32'd0);
        chk("rst.RdD", 32'(RdD), 32'd0);
        chk("rst.ImmExtD", ImmExtD, 32'd0);
        chk("rst.PCD", PCD, 32'd0);
        chk("rst.RD1D", RD1D, 32'd0);
        rst = 1'b0;

        // addi x1,x0,5 at PC 8
        InstrF = 32'h00500093; PCF = 32'd8; PCPlus4F = 32'd12;
        clk_edge();
        #2;
        chk("addi.RdD", 32'(RdD), 32'd1);
        chk("addi.ImmExtD", ImmExtD, 32'd5);
        chk("addi.RegWriteD", 32'(RegWriteD), 32'd1);
        chk("addi.PCD", PCD, 32'd8);
        chk("addi.PCPlus4D", PCPlus4D, 32'd12);

        // Directed decode table
        for (int i = 0; i < 12; i++) begin
            InstrF = tab[i].instr; PCF = 32'(i * 4); PCPlus4F = 32'(i * 4 + 4);
            clk_edge();
            #2;
            chk($sformatf("tab%0d.RdD", i), 32'(RdD), 32'(tab[i].instr[11:7]));
            chk($sformatf("tab%0d.ImmExtD", i), ImmExtD, tab[i].imm);
            chk($sformatf("tab%0d.IllegalD", i), 32'(IllegalD), 32'(tab[i].ill));
            chk($sformatf("tab%0d.RegWriteD", i), 32'(RegWriteD), 32'(tab[i].rw));
            chk($sformatf("tab%0d.MemWriteD", i), 32'(MemWriteD), 32'(tab[i].mw));
            chk($sformatf("tab%0d.JumpD", i), 32'(JumpD), 32'(tab[i].jmp));
            chk($sformatf("tab%0d.BranchD", i), 32'(BranchD), 32'(tab[i].br));
            if (!tab[i].ill) begin
                chk($sformatf("tab%0d.ResultSrcD", i), 32'(ResultSrcD), 32'(tab[i].rsrc));
                chk($sformatf("tab%0d.ALUControlD", i), 32'(ALUControlD), 32'(tab[i].actl));
                if (!tab[i].adc) chk($sformatf("tab%0d.ALUSrcD", i), 32'(ALUSrcD), 32'(tab[i].asrc));
            end
        end

        // Write-through bypass: add x4,x3,x3 while x3 is written
        InstrF = 32'h00318233;
        clk_edge();
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF;
        #2;
        chk("bypass.RD1D", RD1D, 32'hDEADBEEF);
        chk("bypass.RD2D", RD2D, 32'hDEADBEEF);
        clk_edge();
        RegWriteW = 1'b0;
        #2;
        chk("persist.RD1D", RD1D, 32'hDEADBEEF);
        chk("persist.RD2D", RD2D, 32'hDEADBEEF);

        // Writes to x0 are dropped
        InstrF = 32'h00000233;
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'd7;
        clk_edge();
        #2;
        chk("x0_bypass.RD1D", RD1D, 32'd0);
        clk_edge();
        RegWriteW = 1'b0;
        #2;
        chk("x0_read.RD1D", RD1D, 32'd0);

        // Stall holds, flush beats stall
        InstrF = 32'h00500093; PCF = 32'h100; PCPlus4F = 32'h104;
        clk_edge();
        StallD = 1'b1; InstrF = 32'h007372B3; PCF = 32'h200; PCPlus4F = 32'h204;
        clk_edge();
        #2;
        chk("stall.PCD", PCD, 32'h100);
        chk("stall.RdD", 32'(RdD), 32'd1);
        chk("stall.ImmExtD", ImmExtD, 32'd5);
        FlushD = 1'b1;
        clk_edge();
        #2;
        chk("flush.RegWriteD", 32'(RegWriteD), 32'd0);
        chk("flush.PCD", PCD, 32'd0);
        chk("flush.RdD", 32'(RdD), 32'd0);
        chk("flush.Rs1D", 32'(Rs1D), 32'd0);
        chk("flush.ImmExtD", ImmExtD, 32'd0);
        chk("flush.ALUSrcD", 32'(ALUSrcD), 32'd1);
        StallD = 1'b0; FlushD = 1'b0;

        // Reset mid-operation wipes the pipeline register and regfile
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h00001234;
        clk_edge();
        RegWriteW = 1'b0;
        InstrF = 32'h00528233;
        rst = 1'b1;
        clk_edge();
        rst = 1'b0;
        #2;
        chk("midrst.RdD", 32'(RdD), 32'd0);
        chk("midrst.RegWriteD", 32'(RegWriteD), 32'd0);
        clk_edge();
        #2;
        chk("midrst.RD1D", RD1D, 32'd0);
        chk("midrst.RD2D", RD2D, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            StallD    = ($urandom_range(0, 3) == 0);
            FlushD    = ($urandom_range(0, 7) == 0);
            InstrF    = rand_instr();
            PCF       = {$urandom_range(0, 16383), 2'b00};
            PCPlus4F  = PCF + 32'd4;
            RegWriteW = ($urandom_range(0, 1) == 1);
            RdW       = ($urandom_range(0, 3) == 0) ? m_instr[19:15] : 5'($urandom);
            ResultW   = $urandom;
            check_model($sformatf("rnd%0d", n));
            clk_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Contains the IF/ID pipeline register (with stall and flush), the 32x32 register file (with write-back port and write-through bypass), the main/ALU control decoder and the immediate extender.
- Outputs are combinational from the IF/ID register and regfile. They feed the ID/EX register and the hazard unit.

Parameters:
- NOP_INSTR, 32'h00000013, instruction loaded into the IF/ID register on reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- StallD  in  1  hold IF/ID register contents
- FlushD  in  1  replace IF/ID contents with bubble
- InstrF  in  32  instruction from fetch
- PCF  in  32  PC of InstrF
- PCPlus4F  in  32  PCF+4
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- PCD  out  32  PC of decoded instruction
- PCPlus4D  out  32  PCPlus4 of decoded instruction
- RD1D  out  32  rs1 value
- RD2D  out  32  rs2 value
- ImmExtD  out  32  extended immediate
- Rs1D  out  5  Instr[19:15]
- Rs2D  out  5  Instr[24:20]
- RdD  out  5  Instr[11:7]
- RegWriteD  out  1  control
- ResultSrcD  out  2  00 ALU, 01 mem, 10 PC+4
- MemWriteD  out  1  control
- JumpD  out  1  control
- BranchD  out  1  control
- ALUControlD  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcD  out  1  0 reg, 1 imm
- IllegalD  out  1  unsupported opcode/funct

Behaviour:
- IF/ID register (InstrD, PCD, PCPlus4D) update priority on posedge clk:
  - rst: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
  - else FlushD: same values as rst.
  - else StallD: hold.
  - else: load InstrF, PCF, PCPlus4F.
  - FlushD beats StallD when both are asserted.
- Register file: 32x32.
  - rst clears all entries to 0.
  - Write on posedge when RegWriteW && RdW!=0. Writes to x0 are ignored; x0 always reads 0.
  - Writes are not blocked by StallD or FlushD.
- Read ports are combinational.
  - RD1D = ResultW when RegWriteW && RdW!=0 && RdW==Rs1D; otherwise regs[Rs1D]. RD2D is the same with Rs2D.
  - The bypass makes same-cycle write/read return the new value.
- Decoder supports the following (opcode → RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - lw 0000011 → 1, I, 1, 0, 01, 0, add, 0
  - sw 0100011 → 0, S, 1, 1, xx→00, 0, add, 0
  - R 0110011 → 1, –, 0, 0, 00, 0, funct, 0
  - I-ALU 0010011 → 1, I, 1, 0, 00, 0, funct, 0
  - beq 1100011 → 0, B, 0, 0, 00, 1, sub, 0
  - jal 1101111 → 1, J, –, 0, 10, 0, add, 1
- funct decode:
  - funct3 000 → add, except sub when R-type && funct7[5].
  - 010 → slt; 110 → or; 111 → and.
  - Any other funct3 for R/I-ALU, funct7 not in {0000000, 0100000} for R-type, or an unlisted opcode → IllegalD=1.
  - When IllegalD=1, all write/branch/jump controls are forced to 0.
- Immediates (sign bit always Instr[31]):
  - I: {20×s, I[31:20]}
  - S: {20×s, I[31:25], I[11:7]}
  - B: {19×s, I[31], I[7], I[30:25], I[11:8], 0}
  - J: {11×s, I[31], I[19:12], I[20], I[30:21], 0}
  - Non-immediate instructions: ImmExtD = 0.
- Reset values (bubble): RegWriteD=0, MemWriteD=0, JumpD=0, BranchD=0, IllegalD=0, ALUSrcD=1, ALUControlD=000, RdD=0, Rs1D=0, RD1D=0, ImmExtD=0, PCD=0, PCPlus4D=0.
- Latency: one cycle from InstrF to decoded outputs. Reset mid-operation discards the in-flight instruction and all regfile contents.

Test Plan:
- Reset then InstrF=32'h00500093 (addi x1,x0,5), PCF=8 -> next cycle RdD=1, ImmExtD=5, RegWriteD=1, ALUSrcD=1, PCD=8, PCPlus4D=12.
- RegWriteW=1, RdW=3, ResultW=32'hDEADBEEF while decoding add x4,x3,x3 -> RD1D=RD2D=32'hDEADBEEF in the same cycle; value persists after write.
- RegWriteW=1, RdW=0, ResultW=7, then read x0 -> RD1D=0.
- StallD=1 with a new InstrF -> InstrD/PCD hold; StallD=FlushD=1 -> bubble (RegWriteD=0, InstrD=32'h00000013).
- beq with offset -8 (32'hFE000CE3) -> BranchD=1, ALUControlD=001, ImmExtD=32'hFFFFFFF8; jal x1,+2048 -> JumpD=1, ResultSrcD=10, ImmExtD=32'h00000800.
- Opcode 7'b1111111 -> IllegalD=1, RegWriteD=0, MemWriteD=0; R-type funct7=0000001 -> IllegalD=1.
